// File: rtl/axi_strm_tx.sv
// axi_strm_tx: AXI initiator that forwards a local 513-bit stream (512 data + 1 user)
// into a remote axi_strm-style endpoint. Credits are obtained by polling the
// endpoint's W_STAT word (base+64). The read clears the remote count. Data then
// goes out as fixed-length INCR write bursts to base+256.
//
// Optional feature: define AXI_STRM_TX_STATS_EN to add 32-bit wrapping
// counters readable over SoftReg:
//   0x20 = beats, 0x28 = bursts, 0x30 = polls, 0x38 = zero-credit polls.
// With the macro undefined, 0x20-0x38 read the default pattern.
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   sr_req      SoftReg access: 0x00 W base, 0x08 W enable[0], 0x10 R creds,
//               0x18 R {state[7:4], err[1], enable[0]}
//   sr_resp     read response, registered (valid one cycle after the read)
//   axi_m_req   AXI master outputs (AR/R ready, AW/W/B ready)
//   axi_m_rsp   AXI master inputs from the endpoint
//   s_valid, s_data, s_user, s_ready
//               producer stream; a beat moves when s_valid && s_ready
//
// Handshake rule: every channel transfers on the clock edge where valid and
// ready are both high. A valid, once raised, holds its payload stable until
// that edge. s_ready is wready passed straight through during the data phase,
// so no beat is ever buffered here.

package axi_strm_tx_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [63:0] data;
    } SoftRegReq;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } SoftRegResp;

    typedef struct packed {
        logic [15:0]  awid;
        logic [63:0]  awaddr;
        logic [7:0]   awlen;
        logic [2:0]   awsize;
        logic [1:0]   awburst;
        logic         awvalid;
        logic [511:0] wdata;
        logic [63:0]  wstrb;
        logic         wlast;
        logic         wuser;
        logic         wvalid;
        logic         bready;
        logic [15:0]  arid;
        logic [63:0]  araddr;
        logic [7:0]   arlen;
        logic [2:0]   arsize;
        logic [1:0]   arburst;
        logic         arvalid;
        logic         rready;
    } axi_bus_req_t;

    typedef struct packed {
        logic         awready;
        logic         wready;
        logic [15:0]  bid;
        logic [1:0]   bresp;
        logic         bvalid;
        logic         arready;
        logic [15:0]  rid;
        logic [511:0] rdata;
        logic [1:0]   rresp;
        logic         rlast;
        logic         rvalid;
    } axi_bus_rsp_t;
endpackage

module axi_strm_tx
    import axi_strm_tx_pkg::*;
#(
    parameter int          BURST_LEN = 16,
    parameter int          CRED_LD   = 14,
    parameter int          POLL_GAP  = 64,
    parameter logic [15:0] AXI_ID    = 16'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  SoftRegReq    sr_req,
    output SoftRegResp   sr_resp,
    output axi_bus_req_t axi_m_req,
    input  axi_bus_rsp_t axi_m_rsp,
    input  logic         s_valid,
    input  logic [511:0] s_data,
    input  logic         s_user,
    output logic         s_ready
);
    localparam int              CW       = CRED_LD + 1;
    localparam logic [CW-1:0]   CRED_MAX = {1'b1, {CRED_LD{1'b0}}};
    localparam logic [CW-1:0]   BL_C     = CW'(BURST_LEN);
    localparam logic [6:0]      LAST_BT  = 7'(BURST_LEN - 1);
    localparam logic [15:0]     GAP_LAST = 16'(POLL_GAP - 1);
    localparam logic [63:0]     RD_PAT   = 64'hAAAAAAAA55555555;

    typedef enum logic [2:0] {IDLE, POLL_AR, POLL_R, WAIT, WR_AW, WR_W, WR_B} state_t;

    state_t        state, state_next;
    logic [CW-1:0] creds;
    logic [63:0]   base, txn_addr;
    logic          enable, err;
    logic [6:0]    beat_cnt;
    logic [15:0]   gap_cnt;
    logic          cred_ok, last_beat;
    logic          r_hs, aw_hs, w_hs, b_hs, rdata_zero;
    logic [CW:0]   cred_sum;
    logic [CW-1:0] cred_sat;
    logic [63:0]   rd_data;
    logic          sr_wr, sr_rd;
    logic          unused_rsp;

    assign unused_rsp = ^{axi_m_rsp.bid, axi_m_rsp.rid, axi_m_rsp.rresp, axi_m_rsp.rlast};

    assign cred_ok    = (creds >= BL_C);
    assign last_beat  = (beat_cnt == LAST_BT);
    assign rdata_zero = (axi_m_rsp.rdata == '0);
    assign r_hs       = (state == POLL_R) && axi_m_rsp.rvalid;
    assign aw_hs      = (state == WR_AW) && axi_m_rsp.awready;
    assign w_hs       = (state == WR_W) && s_valid && axi_m_rsp.wready;
    assign b_hs       = (state == WR_B) && axi_m_rsp.bvalid;
    assign sr_wr      = sr_req.valid && sr_req.is_write;
    assign sr_rd      = sr_req.valid && !sr_req.is_write;

    // Credit add saturates at 2^CRED_LD; only the low CRED_LD+1 bits of the
    // status word carry the count.
    assign cred_sum = {1'b0, creds} + {1'b0, axi_m_rsp.rdata[CRED_LD:0]};
    assign cred_sat = (cred_sum > {1'b0, CRED_MAX}) ? CRED_MAX : cred_sum[CW-1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next          = state;
        axi_m_req           = '0;
        axi_m_req.awid      = AXI_ID;
        axi_m_req.awaddr    = txn_addr;
        axi_m_req.awlen     = 8'(BURST_LEN - 1);
        axi_m_req.awsize    = 3'b110;
        axi_m_req.awburst   = 2'b01;
        axi_m_req.wdata     = s_data;
        axi_m_req.wuser     = s_user;
        axi_m_req.wstrb     = '1;
        axi_m_req.arid      = AXI_ID;
        axi_m_req.araddr    = txn_addr;
        axi_m_req.arlen     = 8'd0;
        axi_m_req.arsize    = 3'b110;
        axi_m_req.arburst   = 2'b01;
        s_ready             = 1'b0;
        case (state)
            IDLE: begin
                if (enable && cred_ok && s_valid) state_next = WR_AW;
                else if (enable && !cred_ok)      state_next = POLL_AR;
            end
            POLL_AR: begin
                axi_m_req.arvalid = 1'b1;
                if (axi_m_rsp.arready) state_next = POLL_R;
            end
            POLL_R: begin
                axi_m_req.rready = 1'b1;
                if (axi_m_rsp.rvalid) state_next = rdata_zero ? WAIT : IDLE;
            end
            WAIT: begin
                if (gap_cnt == GAP_LAST) state_next = IDLE;
            end
            WR_AW: begin
                axi_m_req.awvalid = 1'b1;
                if (axi_m_rsp.awready) state_next = WR_W;
            end
            WR_W: begin
                axi_m_req.wvalid = s_valid;
                axi_m_req.wlast  = last_beat;
                s_ready          = axi_m_rsp.wready;
                if (w_hs && last_beat) state_next = WR_B;
            end
            WR_B: begin
                axi_m_req.bready = 1'b1;
                if (axi_m_rsp.bvalid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            creds    <= '0;
            base     <= '0;
            enable   <= 1'b0;
            err      <= 1'b0;
            beat_cnt <= '0;
            gap_cnt  <= '0;
            txn_addr <= '0;
        end else begin
            if (sr_wr && sr_req.addr == 32'h00) base   <= sr_req.data;
            if (sr_wr && sr_req.addr == 32'h08) enable <= sr_req.data[0];
            // Address is captured when a transaction starts, so a base write
            // arriving mid-transaction only affects the next AR/AW.
            if (state == IDLE && state_next == POLL_AR) txn_addr <= base + 64'd64;
            if (state == IDLE && state_next == WR_AW)   txn_addr <= base + 64'd256;
            if (r_hs) creds <= cred_sat;
            if (aw_hs) begin
                creds    <= creds - BL_C;
                beat_cnt <= '0;
            end
            if (w_hs) beat_cnt <= beat_cnt + 7'd1;
            gap_cnt <= (state == WAIT) ? gap_cnt + 16'd1 : 16'd0;
            if (b_hs && axi_m_rsp.bresp != 2'b00) err <= 1'b1;
        end
    end

`ifdef AXI_STRM_TX_STATS_EN
    logic [31:0] st_beats, st_bursts, st_polls, st_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_beats  <= '0;
            st_bursts <= '0;
            st_polls  <= '0;
            st_zero   <= '0;
        end else begin
            if (w_hs)               st_beats  <= st_beats + 32'd1;
            if (b_hs)               st_bursts <= st_bursts + 32'd1;
            if (r_hs)               st_polls  <= st_polls + 32'd1;
            if (r_hs && rdata_zero) st_zero   <= st_zero + 32'd1;
        end
    end
`endif

    always_comb begin
        rd_data = RD_PAT;
        case (sr_req.addr)
            32'h10: rd_data = 64'(creds);
            32'h18: rd_data = {56'd0, 1'b0, state, 2'b00, err, enable};
`ifdef AXI_STRM_TX_STATS_EN
            32'h20: rd_data = {32'd0, st_beats};
            32'h28: rd_data = {32'd0, st_bursts};
            32'h30: rd_data = {32'd0, st_polls};
            32'h38: rd_data = {32'd0, st_zero};
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_resp <= '0;
        end else begin
            sr_resp.valid <= sr_rd;
            if (sr_rd) sr_resp.data <= rd_data;
        end
    end
endmodule

// File: tb/tb_axi_strm_tx.sv
// tb_axi_strm_tx: bench for axi_strm_tx. A randomized AXI endpoint and stream
// producer run once per clock. A reference model tracks credits, outstanding
// transactions and the beat stream, and checks the DUT against it.
// Ports of the DUT are all connected; default parameters are used.
module tb_axi_strm_tx;
    import axi_strm_tx_pkg::*;

    localparam int          BL       = 16;
    localparam int          GAP      = 64;
    localparam int          CRED_MAX = 16384;
    localparam int          W        = 513;
    localparam logic [63:0] BASE     = 64'h1000;
    localparam logic [63:0] PAT      = 64'hAAAAAAAA55555555;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    SoftRegReq    sr_req;
    SoftRegResp   sr_resp;
    axi_bus_req_t axi_m_req;
    axi_bus_rsp_t axi_m_rsp;
    logic         s_valid;
    logic [511:0] s_data;
    logic         s_user;
    logic         s_ready;

    always #5 clk = ~clk;

    axi_strm_tx #(.BURST_LEN(16), .CRED_LD(14), .POLL_GAP(64), .AXI_ID(16'h0)) dut (
        .clk(clk), .rst(rst), .sr_req(sr_req), .sr_resp(sr_resp),
        .axi_m_req(axi_m_req), .axi_m_rsp(axi_m_rsp),
        .s_valid(s_valid), .s_data(s_data), .s_user(s_user), .s_ready(s_ready)
    );

    // scoreboard and model state
    logic [W-1:0] exp_q[$];
    logic [31:0]  poll_vals[$];
    logic [31:0]  r_q[$];
    int n_vec = 0, n_err = 0;
    int n_ar = 0, n_r = 0, n_aw = 0, n_b = 0, n_beats = 0, n_zero = 0;
    int cur_beat = 0, cyc = 0, last_zero_cyc = 0, exp_creds = 0;
    int prod_left = 0, b_pend = 0, av_cnt = 0;
    int wready_pct = 80, sv_pct = 80;
    bit zero_armed = 0, err_next = 0;
    bit r_hs = 0, b_hs = 0, p_hs = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // endpoint + producer, driven at negedge, handshakes observed at negedge+1
    initial begin
        logic [31:0] v;
        axi_m_rsp = '0;
        s_valid = 1'b0;
        s_data = '0;
        s_user = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                axi_m_rsp = '0;
                s_valid = 1'b0;
                exp_q.delete();
                r_q.delete();
                b_pend = 0; prod_left = 0; exp_creds = 0; cur_beat = 0;
                zero_armed = 0; r_hs = 0; b_hs = 0; p_hs = 0;
                n_r = n_ar; n_b = n_aw;
                continue;
            end
            if (r_hs) axi_m_rsp.rvalid = 1'b0;
            if (b_hs) axi_m_rsp.bvalid = 1'b0;
            if (p_hs) s_valid = 1'b0;
            r_hs = 0; b_hs = 0; p_hs = 0;
            axi_m_rsp.arready = ($urandom_range(0, 3) != 0);
            axi_m_rsp.awready = ($urandom_range(0, 3) != 0);
            axi_m_rsp.wready  = ($urandom_range(0, 99) < wready_pct);
            if (!axi_m_rsp.rvalid && r_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                axi_m_rsp.rvalid = 1'b1;
                axi_m_rsp.rlast  = 1'b1;
                axi_m_rsp.rdata  = {480'd0, r_q.pop_front()};
            end
            if (!axi_m_rsp.bvalid && b_pend > 0 && $urandom_range(0, 1) == 1) begin
                axi_m_rsp.bvalid = 1'b1;
                axi_m_rsp.bresp  = err_next ? 2'b10 : 2'b00;
                err_next = 0;
                b_pend--;
            end
            if (!s_valid && prod_left > 0 && $urandom_range(0, 99) < sv_pct) begin
                for (int k = 0; k < 16; k++) s_data[k*32 +: 32] = $urandom();
                s_user = 1'($urandom_range(0, 1));
                s_valid = 1'b1;
                exp_q.push_back({s_user, s_data});
                prod_left--;
            end
            #1;
            if (axi_m_req.arvalid || axi_m_req.awvalid) av_cnt++;
            if (axi_m_req.arvalid && zero_armed) begin
                chk("poll_gap", (cyc - last_zero_cyc) >= GAP, 1'b1);
                zero_armed = 0;
            end
            if (axi_m_req.arvalid && axi_m_rsp.arready) begin
                chk("ar_addr", axi_m_req.araddr, BASE + 64);
                chk("ar_len", axi_m_req.arlen, 8'd0);
                chk("ar_size", axi_m_req.arsize, 3'b110);
                chk("ar_burst", axi_m_req.arburst, 2'b01);
                chk("ar_aw_overlap", axi_m_req.awvalid, 1'b0);
                chk("ar_outstanding", (n_ar - n_r) + (n_aw - n_b), 0);
                chk("ar_creds_short", exp_creds < BL, 1'b1);
                v = (poll_vals.size() > 0) ? poll_vals.pop_front() : 32'd0;
                r_q.push_back(v);
                n_ar++;
            end
            if (axi_m_rsp.rvalid && axi_m_req.rready) begin
                v = axi_m_rsp.rdata[31:0];
                exp_creds = exp_creds + int'(v);
                if (exp_creds > CRED_MAX) exp_creds = CRED_MAX;
                if (v == 0) begin
                    n_zero++;
                    zero_armed = 1;
                    last_zero_cyc = cyc;
                end
                n_r++;
                r_hs = 1;
            end
            if (axi_m_req.awvalid && axi_m_rsp.awready) begin
                chk("aw_addr", axi_m_req.awaddr, BASE + 256);
                chk("aw_len", axi_m_req.awlen, 8'(BL - 1));
                chk("aw_size", axi_m_req.awsize, 3'b110);
                chk("aw_burst", axi_m_req.awburst, 2'b01);
                chk("aw_outstanding", (n_ar - n_r) + (n_aw - n_b), 0);
                chk("aw_creds_ok", exp_creds >= BL, 1'b1);
                exp_creds -= BL;
                n_aw++;
                cur_beat = 0;
            end
            p_hs = s_valid && s_ready;
            if (p_hs || (axi_m_req.wvalid && axi_m_rsp.wready))
                chk("stream_vs_w", p_hs, axi_m_req.wvalid && axi_m_rsp.wready);
            if (axi_m_req.wvalid && axi_m_rsp.wready) begin
                if (exp_q.size() == 0) chk("w_queue", exp_q.size(), 1);
                else chk("w_beat", {axi_m_req.wuser, axi_m_req.wdata}, exp_q.pop_front());
                chk("w_strb", axi_m_req.wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
                chk("w_last", axi_m_req.wlast, cur_beat == BL - 1);
                chk("w_in_burst", n_aw - n_b, 1);
                if (axi_m_req.wlast) b_pend++;
                cur_beat++;
                n_beats++;
            end
            if (axi_m_rsp.bvalid && axi_m_req.bready) begin
                chk("b_after_beats", cur_beat, BL);
                n_b++;
                b_hs = 1;
            end
        end
    end

    task automatic sr_write(input logic [31:0] a, input logic [63:0] d);
        @(negedge clk);
        sr_req.valid = 1'b1; sr_req.is_write = 1'b1; sr_req.addr = a; sr_req.data = d;
        @(negedge clk);
        sr_req.valid = 1'b0; sr_req.is_write = 1'b0;
    endtask

    task automatic sr_read(input logic [31:0] a, output logic [63:0] d);
        @(negedge clk);
        sr_req.valid = 1'b1; sr_req.is_write = 1'b0; sr_req.addr = a; sr_req.data = '0;
        @(negedge clk);
        sr_req.valid = 1'b0;
        chk("sr_resp_valid", sr_resp.valid, 1'b1);
        d = sr_resp.data;
    endtask

    // sel: 0 polls, 1 bursts done, 2 AW issued, 3 beat in burst, 4 zero polls
    task automatic wait_cnt(input string tag, input int sel, input int target);
        int got;
        got = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #2;
            case (sel)
                0: got = n_r;
                1: got = n_b;
                2: got = n_aw;
                3: got = cur_beat;
                default: got = n_zero;
            endcase
            if (got >= target) return;
        end
        chk(tag, got, target);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_arvalid"}, axi_m_req.arvalid, 1'b0);
        chk({tag, "_awvalid"}, axi_m_req.awvalid, 1'b0);
        chk({tag, "_wvalid"}, axi_m_req.wvalid, 1'b0);
        chk({tag, "_rready"}, axi_m_req.rready, 1'b0);
        chk({tag, "_bready"}, axi_m_req.bready, 1'b0);
        chk({tag, "_s_ready"}, s_ready, 1'b0);
        chk({tag, "_sr_valid"}, sr_resp.valid, 1'b0);
    endtask

    initial begin
        logic [63:0] d;
        sr_req = '0;
        repeat (3) @(negedge clk);
        #2;
        check_idle_outputs("rst");
        @(posedge clk); #3 rst = 1'b0;

        sr_read(32'h10, d); chk("rst_creds", d, 64'd0);
        sr_read(32'h18, d); chk("rst_status", d, 64'd0);
        sr_read(32'h40, d); chk("unmapped_rd", d, PAT);
        sr_read(32'h00, d); chk("wo_base_rd", d, PAT);
`ifdef AXI_STRM_TX_STATS_EN
        sr_read(32'h20, d); chk("rst_stat_beats", d, 64'd0);
`else
        sr_read(32'h20, d); chk("stats_absent", d, PAT);
`endif

        // first poll returns 64, then one burst with the producer running
        poll_vals.push_back(32'd64);
        sr_write(32'h00, BASE);
        sr_write(32'h08, 64'd1);
        wait_cnt("t1_poll_timeout", 0, 1);
        repeat (10) @(negedge clk);
        chk("t1_no_aw_idle_stream", n_aw, 0);
        sr_read(32'h10, d); chk("t1_creds_64", d, 64'd64);
        prod_left = 16;
        wait_cnt("t1_burst_timeout", 1, 1);
        repeat (5) @(negedge clk);
        sr_read(32'h10, d); chk("t1_creds_48", d, 64'(exp_creds));

        // drain credits; endpoint then answers 0 and the gap check applies
        prod_left = 48;
        wait_cnt("t2_burst_timeout", 1, 4);
        wait_cnt("t2_zero_timeout", 4, 3);
        chk("t2_no_extra_aw", n_aw, 4);

        // two polls of 8 before a burst becomes possible
        poll_vals.push_back(32'd8);
        poll_vals.push_back(32'd8);
        prod_left = 16;
        wait_cnt("t3_burst_timeout", 1, 5);
        repeat (5) @(negedge clk);
        sr_read(32'h10, d); chk("t3_creds_0", d, 64'(exp_creds));

        // error response sticks; later bursts keep the same shape
        err_next = 1;
        poll_vals.push_back(32'd32);
        prod_left = 32;
        wait_cnt("t4_burst_timeout", 1, 7);
        sr_read(32'h18, d); chk("t4_err_en", d[1:0], 2'b11);

        // enable dropped mid-burst under throttling: burst finishes, then quiet
        wready_pct = 40; sv_pct = 50;
        poll_vals.push_back(32'd16);
        prod_left = 16;
        wait_cnt("t5_aw_timeout", 2, 8);
        wait_cnt("t5_beat_timeout", 3, 5);
        sr_write(32'h08, 64'd0);
        wait_cnt("t5_b_timeout", 1, 8);
        begin
            int av0;
            av0 = av_cnt;
            repeat (200) @(negedge clk);
            chk("t5_quiet", av_cnt - av0, 0);
        end
        chk("t5_total_beats", n_beats, 8 * BL);
        sr_read(32'h18, d); chk("t5_status", d, 64'h2);
`ifdef AXI_STRM_TX_STATS_EN
        sr_read(32'h20, d); chk("stat_beats", d, 64'(n_beats));
        sr_read(32'h28, d); chk("stat_bursts", d, 64'(n_b));
        sr_read(32'h30, d); chk("stat_polls", d, 64'(n_r));
        sr_read(32'h38, d); chk("stat_zero", d, 64'(n_zero));
`else
        sr_read(32'h28, d); chk("stats_absent_28", d, PAT);
        sr_read(32'h38, d); chk("stats_absent_38", d, PAT);
`endif

        // reset in the middle of a burst abandons it
        wready_pct = 80; sv_pct = 80;
        poll_vals.push_back(32'd16);
        prod_left = 16;
        sr_write(32'h08, 64'd1);
        wait_cnt("t6_aw_timeout", 2, 9);
        wait_cnt("t6_beat_timeout", 3, 3);
        @(posedge clk); #3 rst = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check_idle_outputs("mid_rst");
        @(posedge clk); #3 rst = 1'b0;
        sr_read(32'h10, d); chk("mid_rst_creds", d, 64'd0);
        sr_read(32'h18, d); chk("mid_rst_status", d, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
